mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the pipelined core's instruction-fetch port and its data (load/store) port.
- Arbitrates between the two requesters and sequences each access with a req/ack handshake to variable-latency memory.
- Returns read data and a completion pulse to the winning requester; the core stalls on a missing completion.
- Sits between the core and the unified memory model in the top level.

---
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port unified memory between the core's instruction-fetch
// port (i_*) and its load/store port (d_*). When both ports request, the data
// port wins. After MAX_D_BURST data grants in a row with a fetch still waiting,
// the fetch is forced to win. Each access is a req/ack handshake with
// variable-latency memory. A hung access is aborted after TIMEOUT cycles.
//
// Ports:
//   clk, clr          clock; synchronous active-high reset
//   i_req/i_addr      fetch request (held until i_done) and fetch address
//   i_rdata/i_done    fetched word, valid with the single-cycle i_done pulse
//   d_req/d_we        data request (held until d_done); 1=store, 0=load
//   d_addr/d_wdata    data address and store data
//   d_rdata/d_done    load data, valid with the single-cycle d_done pulse
//   mem_req/mem_we    memory request and write enable (held for the whole access)
//   mem_addr/mem_wdata  memory address and write data, latched at grant
//   mem_rdata/mem_ack memory read data and one-cycle completion
//   grant_d           high while the data port owns memory
//   err               one-cycle pulse after a timeout abort
module mem_port_arbiter #(
   parameter int unsigned MAX_D_BURST = 4,
   parameter int unsigned TIMEOUT     = 1023
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_done,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        grant_d,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2
   } arbState_t;

   arbState_t   stateReg;
   arbState_t   stateNext;
   logic [31:0] burstCnt;
   logic [31:0] timeoutCnt;
   logic        errReg;
   logic        busy;
   logic        pickD;
   logic        pickI;
   logic        timeoutHit;

   always_comb begin
      stateNext = stateReg;
      i_done    = 1'b0;
      d_done    = 1'b0;
      i_rdata   = '0;
      d_rdata   = '0;
      busy      = (stateReg != IDLE);
      // Data has priority unless it has used up its burst allowance while a
      // fetch is waiting.
      pickD     = d_req && (!i_req || (burstCnt < MAX_D_BURST));
      pickI     = !pickD && i_req;
      // An ack in the threshold cycle takes precedence over the abort.
      timeoutHit = (TIMEOUT != 0) && busy && !mem_ack &&
                   (timeoutCnt == TIMEOUT - 1);

      case (stateReg)
         IDLE: begin
            if (pickD) begin
               stateNext = D_BUSY;
            end else if (pickI) begin
               stateNext = I_BUSY;
            end
         end
         I_BUSY: begin
            if (mem_ack) begin
               i_done    = 1'b1;
               i_rdata   = mem_rdata;
               stateNext = IDLE;
            end else if (timeoutHit) begin
               stateNext = IDLE;
            end
         end
         D_BUSY: begin
            if (mem_ack) begin
               d_done    = 1'b1;
               d_rdata   = mem_rdata;
               stateNext = IDLE;
            end else if (timeoutHit) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         stateReg   <= IDLE;
         mem_addr   <= '0;
         mem_we     <= 1'b0;
         mem_wdata  <= '0;
         burstCnt   <= '0;
         timeoutCnt <= '0;
         errReg     <= 1'b0;
      end else begin
         stateReg <= stateNext;
         errReg   <= timeoutHit;
         if (stateReg == IDLE) begin
            // Clearing in IDLE means every BUSY entry starts from zero.
            timeoutCnt <= '0;
            // The winner's request is latched so memory sees stable signals
            // even if the requester changes its inputs mid-access.
            if (pickD) begin
               mem_addr  <= d_addr;
               mem_we    <= d_we;
               mem_wdata <= d_wdata;
            end else if (pickI) begin
               mem_addr  <= i_addr;
               mem_we    <= 1'b0;
               mem_wdata <= '0;
            end
            if (pickD && i_req) begin
               if (burstCnt < MAX_D_BURST) begin
                  burstCnt <= burstCnt + 32'd1;
               end
            end else if (pickI || !i_req) begin
               burstCnt <= '0;
            end
         end else if (!mem_ack) begin
            timeoutCnt <= timeoutCnt + 32'd1;
         end
      end
   end

   assign mem_req = (stateReg != IDLE);
   assign grant_d = (stateReg == D_BUSY);
   assign err     = errReg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. A behavioural memory responder acks each
// access after a programmable number of BUSY cycles. Expected completions are
// queued when stimulus is driven, and a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

   localparam int unsigned MAXB = 4;
   localparam int unsigned TMO  = 8;

   localparam int K_I   = 0;
   localparam int K_DL  = 1;
   localparam int K_DS  = 2;
   localparam int K_ERR = 3;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic [31:0] i_rdata;
   logic        i_done;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        grant_d;
   logic        err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          kind;
      logic [31:0] data;
   } exp_t;
   exp_t expQ[$];

   typedef struct {
      bit          isData;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] expRdata;
   } vec_t;

   mem_port_arbiter #(.MAX_D_BURST(MAXB), .TIMEOUT(TMO)) dut (
      .clk(clk), .clr(clr),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .grant_d(grant_d), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- memory responder ----------------
   logic [31:0] memStore [logic [31:0]];
   int  ackLat = 0;
   bit  ackNever = 1'b0;
   int  injectReq = 0;
   int  injectSeen = 0;
   int  busyCnt = 0;

   function automatic logic [31:0] memRead(input logic [31:0] a);
      if (memStore.exists(a)) return memStore[a];
      return a ^ 32'h5A5A5A5A;
   endfunction

   always begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (injectReq != injectSeen) begin
         injectSeen = injectReq;
         mem_ack    = 1'b1;
         mem_rdata  = 32'hBAD0BAD0;
      end else if (mem_req && !ackNever) begin
         if (busyCnt >= ackLat) begin
            mem_ack   = 1'b1;
            mem_rdata = memRead(mem_addr);
            if (mem_we) memStore[mem_addr] = mem_wdata;
            busyCnt   = 0;
         end else begin
            busyCnt++;
         end
      end else begin
         busyCnt = 0;
      end
   end

   // ---------------- completion monitor / scoreboard ----------------
   int   monKind;
   exp_t monExp;
   always @(negedge clk) begin
      if (!clr) begin
         if (i_done || d_done || err) begin
            monKind = err ? K_ERR : (i_done ? K_I : (mem_we ? K_DS : K_DL));
            $display("txn kind=%0d addr=0x%08h i_rdata=0x%08h d_rdata=0x%08h t=%0t",
                     monKind, mem_addr, i_rdata, d_rdata, $time);
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: got kind %0d, expected no event", monKind);
            end else begin
               monExp = expQ.pop_front();
               check("event_kind", 32'(monKind), 32'(monExp.kind));
               if (monExp.kind == K_I)  check("i_rdata", i_rdata, monExp.data);
               if (monExp.kind == K_DL) check("d_rdata", d_rdata, monExp.data);
            end
         end
         if (!i_done) check("i_rdata_zero_when_idle", i_rdata, 32'h0);
         if (!d_done) check("d_rdata_zero_when_idle", d_rdata, 32'h0);
      end
   end

   // ---------------- one table-driven access ----------------
   task automatic runVec(input vec_t v, input int idx);
      bit seenGrant = 1'b0;
      bit done = 1'b0;
      ackLat = v.lat;
      expQ.push_back('{v.isData ? (v.we ? K_DS : K_DL) : K_I, v.expRdata});
      if (v.isData) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         i_req = 1'b1; i_addr = v.addr;
      end
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (mem_req && !seenGrant) begin
            seenGrant = 1'b1;
            check("vec_mem_addr", mem_addr, v.addr);
            check("vec_mem_we", 32'(mem_we), v.isData ? 32'(v.we) : 32'h0);
            check("vec_grant_d", 32'(grant_d), 32'(v.isData));
            if (v.isData && v.we) check("vec_mem_wdata", mem_wdata, v.wdata);
         end
         if ((v.isData && d_done) || (!v.isData && i_done)) begin
            done = 1'b1;
            d_req = 1'b0;
            i_req = 1'b0;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL vec%0d_timeout: no completion within 40 cycles, expected done", idx);
         d_req = 1'b0; i_req = 1'b0;
         expQ.delete();
      end
      @(negedge clk);
      check("vec_idle_after_done", 32'(mem_req), 32'h0);
   endtask

   vec_t vecs[7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int dCyc;
      int iCyc;
      int grants;
      int busyCycles;
      bit prevReq;
      bit sawErr;
      bit sawGrant;
      logic [5:0] orderBits;

      vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,          2, 32'h0050_0093};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 0, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_2004, 32'h0,          1, 32'hDEAD_BEEF};
      vecs[3] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,          3, 32'h5A5A_6A5A};
      vecs[4] = '{1'b1, 1'b1, 32'h0000_3000, 32'h1234_5678, 0, 32'h0};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,          0, 32'h1234_5678};
      vecs[6] = '{1'b0, 1'b0, 32'h0000_3000, 32'h0,          1, 32'h1234_5678};

      memStore[32'h0000_0100] = 32'h0050_0093;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 32'h0);
      check("rst_mem_we", 32'(mem_we), 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_grant_d", 32'(grant_d), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_done", 32'({i_done, d_done}), 32'h0);
      clr = 1'b0;
      @(negedge clk);

      // Single accesses
      for (int k = 0; k < 7; k++) runVec(vecs[k], k);

      // Simultaneous store and fetch: data wins, fetch one IDLE cycle later
      ackLat = 0;
      expQ.push_back('{K_DS, 32'h0});
      expQ.push_back('{K_I, 32'h0050_0093});
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF;
      i_req = 1'b1; i_addr = 32'h100;
      dCyc = -1; iCyc = -1;
      for (int c = 0; c < 40 && (d_req || i_req); c++) begin
         @(negedge clk);
         if (mem_req && grant_d && dCyc < 0) begin
            dCyc = c;
            check("simul_d_we", 32'(mem_we), 32'h1);
            check("simul_d_wdata", mem_wdata, 32'hDEADBEEF);
            check("simul_d_addr", mem_addr, 32'h2004);
         end
         if (mem_req && !grant_d && iCyc < 0) begin
            iCyc = c;
            check("simul_i_addr", mem_addr, 32'h100);
            check("simul_i_we", 32'(mem_we), 32'h0);
         end
         if (d_done) d_req = 1'b0;
         if (i_done) i_req = 1'b0;
      end
      check("simul_data_first", 32'(dCyc >= 0 && iCyc > dCyc), 32'h1);
      check("simul_gap", 32'(iCyc - dCyc), 32'h2);
      if (d_req || i_req) begin
         checks++; errors++;
         $display("FAIL simul_timeout: requests still pending, expected both done");
         d_req = 1'b0; i_req = 1'b0; expQ.delete();
      end
      @(negedge clk);

      // Burst limit: D,D,D,D,I,D
      for (int k = 0; k < 4; k++) expQ.push_back('{K_DL, 32'h5A5A_1A5A});
      expQ.push_back('{K_I, 32'h0050_0093});
      expQ.push_back('{K_DL, 32'h5A5A_1A5A});
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
      i_req = 1'b1; i_addr = 32'h100;
      grants = 0; prevReq = 1'b0; orderBits = '0;
      for (int c = 0; c < 100 && (d_req || i_req); c++) begin
         @(negedge clk);
         if (mem_req && !prevReq && grants < 6) begin
            orderBits[grants] = grant_d;
            grants++;
         end
         prevReq = mem_req;
         if (grants == 6 && (d_done || i_done)) begin
            d_req = 1'b0; i_req = 1'b0;
         end
      end
      check("burst_grant_count", 32'(grants), 32'd6);
      check("burst_order", 32'(orderBits), 32'h2F);
      if (d_req || i_req) begin
         d_req = 1'b0; i_req = 1'b0; expQ.delete();
      end
      @(negedge clk);

      // Timeout abort and re-grant
      ackNever = 1'b1;
      expQ.push_back('{K_ERR, 32'h0});
      expQ.push_back('{K_DL, 32'h5A5A_1A5A});
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
      busyCycles = 0; sawErr = 1'b0;
      for (int c = 0; c < 60 && d_req; c++) begin
         @(negedge clk);
         if (grant_d && !sawErr) busyCycles++;
         if (err) begin
            sawErr = 1'b1;
            ackNever = 1'b0;
            check("timeout_busy_cycles", 32'(busyCycles), 32'd8);
            check("timeout_req_dropped", 32'(mem_req), 32'h0);
         end
         if (d_done) begin
            d_req = 1'b0;
            check("timeout_regrant", 32'(sawErr), 32'h1);
         end
      end
      if (d_req) begin
         checks++; errors++;
         $display("FAIL timeout_seq: d_req never completed, expected err then done");
         d_req = 1'b0; expQ.delete();
      end
      ackNever = 1'b0;
      @(negedge clk);

      // Reset during D_BUSY followed by a stale ack
      ackNever = 1'b1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
      sawGrant = 1'b0;
      for (int c = 0; c < 20 && !sawGrant; c++) begin
         @(negedge clk);
         if (grant_d) sawGrant = 1'b1;
      end
      check("clr_seq_granted", 32'(sawGrant), 32'h1);
      clr = 1'b1; d_req = 1'b0; injectReq++;
      @(negedge clk);
      check("clr_mem_req", 32'(mem_req), 32'h0);
      check("clr_stale_ack_no_done", 32'({i_done, d_done}), 32'h0);
      check("clr_err", 32'(err), 32'h0);
      clr = 1'b0;
      @(negedge clk);
      check("clr_stay_idle", 32'(mem_req), 32'h0);
      check("clr_no_done_after", 32'({i_done, d_done, err}), 32'h0);
      ackNever = 1'b0;
      @(negedge clk);

      // Ack coinciding with the timeout threshold cycle
      ackLat = 7;
      expQ.push_back('{K_DL, 32'hDEAD_BEEF});
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2004;
      busyCycles = 0;
      for (int c = 0; c < 40 && d_req; c++) begin
         @(negedge clk);
         if (grant_d) busyCycles++;
         check("coincide_no_err", 32'(err), 32'h0);
         if (d_done) d_req = 1'b0;
      end
      check("coincide_busy_cycles", 32'(busyCycles), 32'd8);
      if (d_req) begin
         d_req = 1'b0; expQ.delete();
      end
      repeat (2) begin
         @(negedge clk);
         check("coincide_err_after", 32'(err), 32'h0);
      end

      check("queue_drained", 32'(expQ.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
